// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the PC generation unit: FSM states, redirect kinds
// and default parameter values.
`timescale 1ns/1ps

package pc_gen_unit_pkg;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Kind of redirect held in the pending slot, or presented live.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_TRAP = 2'd2
    } rd_kind_e;

    localparam int          DEF_XLEN       = 32;
    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam int          DEF_STEP       = 4;
    localparam int          DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Bundle between the PC unit, its redirect sources and the fetch stage.
// master: the PC unit itself. slave: the surrounding control/fetch logic.
`timescale 1ns/1ps

interface pc_gen_unit_if #(
    parameter int XLEN = 32
);
    logic            if_ready;
    logic            branch;
    logic [XLEN-1:0] branch_addr;
    logic            trap;
    logic [XLEN-1:0] trap_vec;
    logic            halt_req;
    logic            resume;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_step;
    logic            pc_valid;
    logic            halted;
    logic            misalign_err;

    modport master (
        input  if_ready, branch, branch_addr, trap, trap_vec, halt_req, resume,
        output pc, pc_plus_step, pc_valid, halted, misalign_err
    );

    modport slave (
        output if_ready, branch, branch_addr, trap, trap_vec, halt_req, resume,
        input  pc, pc_plus_step, pc_valid, halted, misalign_err
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: trap-over-branch selection, target alignment, misalign
// detection and the single-entry pending redirect used while fetch is parked.
`timescale 1ns/1ps

module pc_redirect_arb
    import pc_gen_unit_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_addr,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            hold,        // fetch parked: live requests go to the pending slot
    input  logic            clear_pend,  // leaving edge: pending slot is consumed
    output logic            live_valid,
    output logic [XLEN-1:0] live_target,
    output logic            pend_valid,
    output logic [XLEN-1:0] pend_target,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((1 << ALIGN_BITS) - 1);

    rd_kind_e        live_kind;
    logic [XLEN-1:0] live_raw;
    logic            live_misaligned;
    logic            take_pend;
    logic            accepted;

    rd_kind_e        pend_kind_q, pend_kind_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            misalign_q,  misalign_d;

    // Select the live request, align it, and decide what the pending slot and error flag do.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        live_kind   = RD_NONE;
        live_raw    = '0;
        pend_kind_d = pend_kind_q;
        pend_addr_d = pend_addr_q;

        if (trap) begin
            live_kind = RD_TRAP;
            live_raw  = trap_vec;
        end else if (branch) begin
            live_kind = RD_BR;
            live_raw  = branch_addr;
        end

        live_valid      = (live_kind != RD_NONE);
        live_target     = live_raw & ~LOW_MASK;
        live_misaligned = (live_raw & LOW_MASK) != '0;

        // A branch may replace a pending branch but never a pending trap.
        take_pend  = hold && live_valid && (live_kind == RD_TRAP || pend_kind_q != RD_TRAP);
        accepted   = !hold && live_valid;
        misalign_d = live_misaligned && (accepted || take_pend);

        if (clear_pend) begin
            pend_kind_d = RD_NONE;
        end else if (take_pend) begin
            pend_kind_d = live_kind;
            pend_addr_d = live_target;
        end
    end

    // Pending slot and misalign pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the pending address is reset along with its kind so a stale target never survives reset.
        if (rst) begin
            pend_kind_q <= RD_NONE;
            pend_addr_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            pend_kind_q <= pend_kind_d;
            pend_addr_q <= pend_addr_d;
            misalign_q  <= misalign_d;
        end
    end

    assign pend_valid   = (pend_kind_q != RD_NONE);
    assign pend_target  = pend_addr_q;
    assign misalign_err = misalign_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: holds the PC, steps it on consumed fetches, applies
// trap/branch redirects and parks fetch in HALT until resumed.
`timescale 1ns/1ps

module pc_gen_unit
    import pc_gen_unit_pkg::*;
#(
    parameter int              XLEN       = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter int              STEP       = DEF_STEP,
    parameter int              ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic          clk,
    input  logic          rst,
    pc_gen_unit_if.master bus
);

    state_e          state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            halted_q,   halted_d;

    logic [XLEN-1:0] pc_plus;
    logic            hold;
    logic            clear_pend;
    logic            live_valid;
    logic [XLEN-1:0] live_target;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;

    assign pc_plus    = pc_q + XLEN'(STEP);
    assign hold       = (state_q == ST_HALT) && !bus.resume;
    assign clear_pend = (state_q == ST_BOOT) || ((state_q == ST_HALT) && bus.resume);

    pc_redirect_arb #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .branch       (bus.branch),
        .branch_addr  (bus.branch_addr),
        .trap         (bus.trap),
        .trap_vec     (bus.trap_vec),
        .hold         (hold),
        .clear_pend   (clear_pend),
        .live_valid   (live_valid),
        .live_target  (live_target),
        .pend_valid   (pend_valid),
        .pend_target  (pend_target),
        .misalign_err (bus.misalign_err)
    );

    // Next state and next PC: live redirect, then pending redirect on leaving BOOT/HALT, then step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (live_valid)      pc_d = live_target;
                else if (pend_valid) pc_d = pend_target;
            end
            ST_RUN: begin
                if (live_valid)                    pc_d = live_target;
                else if (pc_valid_q && bus.if_ready) pc_d = pc_plus;
                if (bus.halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (bus.resume) begin
                    state_d = ST_RUN;
                    if (live_valid)      pc_d = live_target;
                    else if (pend_valid) pc_d = pend_target;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        pc_valid_d = (state_d == ST_RUN);
        halted_d   = (state_d == ST_HALT);
    end

    // FSM state, PC and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus_step = pc_plus;
    assign bus.pc_valid     = pc_valid_q;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: default build, a compressed build
// (STEP=2, ALIGN_BITS=1) and a 16-bit build, checked through a scoreboard.
`timescale 1ns/1ps

module tb_pc_gen_unit;

    logic clk;
    logic rst;

    pc_gen_unit_if #(.XLEN(32)) bus_a ();
    pc_gen_unit_if #(.XLEN(32)) bus_c ();
    pc_gen_unit_if #(.XLEN(16)) bus_w ();

    pc_gen_unit #(.XLEN(32)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    pc_gen_unit #(.XLEN(32), .STEP(2), .ALIGN_BITS(1)) u_c (.clk(clk), .rst(rst), .bus(bus_c));
    pc_gen_unit #(.XLEN(16), .RESET_VEC(16'h0000)) u_w (.clk(clk), .rst(rst), .bus(bus_w));

    typedef struct {
        string       tag;
        int          which;
        logic [31:0] pc;
        logic [31:0] pcs;
        logic        valid;
        logic        halted;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the state after the next edge, then pop and compare it.
    task automatic cyc(input string tag, input int which, input logic [31:0] pc,
                       input logic valid, input logic halted, input logic mis);
        exp_t e;
        exp_t got;
        logic [31:0] opc, ops;
        logic ov, oh, om;
        e.tag = tag; e.which = which; e.pc = pc;
        e.valid = valid; e.halted = halted; e.mis = mis;
        case (which)
            1:       e.pcs = pc + 32'd2;
            2:       e.pcs = (pc + 32'd4) & 32'h0000_FFFF;
            default: e.pcs = pc + 32'd4;
        endcase
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        case (got.which)
            1: begin
                opc = bus_c.pc; ops = bus_c.pc_plus_step;
                ov = bus_c.pc_valid; oh = bus_c.halted; om = bus_c.misalign_err;
            end
            2: begin
                opc = {16'h0, bus_w.pc}; ops = {16'h0, bus_w.pc_plus_step};
                ov = bus_w.pc_valid; oh = bus_w.halted; om = bus_w.misalign_err;
            end
            default: begin
                opc = bus_a.pc; ops = bus_a.pc_plus_step;
                ov = bus_a.pc_valid; oh = bus_a.halted; om = bus_a.misalign_err;
            end
        endcase
        check({got.tag, ".pc"},       opc,          got.pc);
        check({got.tag, ".pc_plus"},  ops,          got.pcs);
        check({got.tag, ".valid"},    32'(ov),      32'(got.valid));
        check({got.tag, ".halted"},   32'(oh),      32'(got.halted));
        check({got.tag, ".misalign"}, 32'(om),      32'(got.mis));
    endtask

    initial begin
        rst = 1'b1;
        bus_a.if_ready = 1'b1; bus_a.branch = 1'b0; bus_a.branch_addr = '0;
        bus_a.trap = 1'b0; bus_a.trap_vec = '0; bus_a.halt_req = 1'b0; bus_a.resume = 1'b0;
        bus_c.if_ready = 1'b0; bus_c.branch = 1'b0; bus_c.branch_addr = '0;
        bus_c.trap = 1'b0; bus_c.trap_vec = '0; bus_c.halt_req = 1'b0; bus_c.resume = 1'b0;
        bus_w.if_ready = 1'b0; bus_w.branch = 1'b0; bus_w.branch_addr = '0;
        bus_w.trap = 1'b0; bus_w.trap_vec = '0; bus_w.halt_req = 1'b0; bus_w.resume = 1'b0;

        // Reset state
        #1;
        check("reset.pc",       bus_a.pc,              32'h0);
        check("reset.pc_plus",  bus_a.pc_plus_step,    32'h4);
        check("reset.valid",    32'(bus_a.pc_valid),   32'h0);
        check("reset.halted",   32'(bus_a.halted),     32'h0);
        check("reset.misalign", 32'(bus_a.misalign_err), 32'h0);
        #19;
        rst = 1'b0;
        #1;
        check("boot.pc",    bus_a.pc,            32'h0);
        check("boot.valid", 32'(bus_a.pc_valid), 32'h0);

        // Sequential stepping and stall
        cyc("run0", 0, 32'h0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) cyc("inc", 0, 32'(i * 4), 1, 0, 0);
        bus_a.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("stall", 0, 32'h10, 1, 0, 0);
        bus_a.if_ready = 1'b1;
        for (int i = 5; i <= 10; i++) cyc("inc2", 0, 32'(i * 4), 1, 0, 0);

        // Redirects and priority
        bus_a.if_ready = 1'b0;
        bus_a.branch = 1'b1; bus_a.branch_addr = 32'h100;
        cyc("br", 0, 32'h100, 1, 0, 0);
        bus_a.trap = 1'b1; bus_a.trap_vec = 32'h80; bus_a.branch_addr = 32'h200;
        cyc("trap_wins", 0, 32'h80, 1, 0, 0);
        bus_a.trap = 1'b0; bus_a.if_ready = 1'b1; bus_a.branch_addr = 32'h104;
        cyc("br_flush", 0, 32'h104, 1, 0, 0);
        bus_a.branch = 1'b0; bus_a.if_ready = 1'b0;

        // Halt with buffered redirects
        bus_a.halt_req = 1'b1;
        cyc("halt", 0, 32'h104, 0, 1, 0);
        bus_a.halt_req = 1'b0; bus_a.branch = 1'b1; bus_a.branch_addr = 32'h300;
        cyc("h_br", 0, 32'h104, 0, 1, 0);
        bus_a.branch = 1'b0; bus_a.trap = 1'b1; bus_a.trap_vec = 32'h40;
        cyc("h_trap", 0, 32'h104, 0, 1, 0);
        bus_a.trap = 1'b0; bus_a.branch = 1'b1; bus_a.branch_addr = 32'h500;
        cyc("h_br2", 0, 32'h104, 0, 1, 0);
        bus_a.branch = 1'b0; bus_a.resume = 1'b1;
        cyc("resume", 0, 32'h40, 1, 0, 0);
        bus_a.resume = 1'b0;
        cyc("hold", 0, 32'h40, 1, 0, 0);
        bus_a.halt_req = 1'b1;
        cyc("halt2", 0, 32'h40, 0, 1, 0);
        bus_a.halt_req = 1'b0; bus_a.resume = 1'b1;
        cyc("pend_clr", 0, 32'h40, 1, 0, 0);
        cyc("res_ign", 0, 32'h40, 1, 0, 0);
        bus_a.halt_req = 1'b1;
        cyc("halt_wins", 0, 32'h40, 0, 1, 0);
        bus_a.halt_req = 1'b0;
        cyc("resume2", 0, 32'h40, 1, 0, 0);
        bus_a.resume = 1'b0;
        bus_a.branch = 1'b1; bus_a.branch_addr = 32'h600; bus_a.halt_req = 1'b1;
        cyc("br_halt", 0, 32'h600, 0, 1, 0);
        bus_a.branch = 1'b0; bus_a.halt_req = 1'b0; bus_a.trap = 1'b1; bus_a.trap_vec = 32'h900;
        cyc("h_trap2", 0, 32'h600, 0, 1, 0);
        bus_a.trap = 1'b0; bus_a.resume = 1'b1; bus_a.branch = 1'b1; bus_a.branch_addr = 32'h700;
        cyc("live_beats", 0, 32'h700, 1, 0, 0);
        bus_a.resume = 1'b0; bus_a.branch = 1'b0; bus_a.halt_req = 1'b1;
        cyc("halt3", 0, 32'h700, 0, 1, 0);
        bus_a.halt_req = 1'b0; bus_a.resume = 1'b1;
        cyc("pend_clr2", 0, 32'h700, 1, 0, 0);
        bus_a.resume = 1'b0;

        // Alignment and misalign pulse
        bus_a.branch = 1'b1; bus_a.branch_addr = 32'h103;
        cyc("mis_br", 0, 32'h100, 1, 0, 1);
        bus_a.branch = 1'b0;
        cyc("mis_end", 0, 32'h100, 1, 0, 0);
        bus_a.halt_req = 1'b1;
        cyc("halt4", 0, 32'h100, 0, 1, 0);
        bus_a.halt_req = 1'b0; bus_a.trap = 1'b1; bus_a.trap_vec = 32'h43;
        cyc("mis_latch", 0, 32'h100, 0, 1, 1);
        bus_a.trap = 1'b0; bus_a.branch = 1'b1; bus_a.branch_addr = 32'h201;
        cyc("mis_drop", 0, 32'h100, 0, 1, 0);
        bus_a.branch = 1'b0; bus_a.resume = 1'b1;
        cyc("resume3", 0, 32'h40, 1, 0, 0);
        bus_a.resume = 1'b0;

        // Compressed build
        bus_c.branch = 1'b1; bus_c.branch_addr = 32'h103; bus_c.if_ready = 1'b1;
        cyc("c_mis", 1, 32'h102, 1, 0, 1);
        bus_c.branch = 1'b0;
        cyc("c_step", 1, 32'h104, 1, 0, 0);
        bus_c.if_ready = 1'b0;

        // 16-bit wrap
        bus_w.branch = 1'b1; bus_w.branch_addr = 32'hFFFC; bus_w.if_ready = 1'b1;
        cyc("w_top", 2, 32'hFFFC, 1, 0, 0);
        bus_w.branch = 1'b0;
        cyc("w_wrap", 2, 32'h0000, 1, 0, 0);
        cyc("w_after", 2, 32'h0004, 1, 0, 0);

        // Mid-run reset with a pending trap in the default build
        bus_a.halt_req = 1'b1;
        cyc("pre_rst_halt", 0, 32'h40, 0, 1, 0);
        bus_a.halt_req = 1'b0; bus_a.trap = 1'b1; bus_a.trap_vec = 32'h80;
        cyc("pre_rst_trap", 0, 32'h40, 0, 1, 0);
        bus_a.trap = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid.w_pc",    {16'h0, bus_w.pc},     32'h0);
        check("rst_mid.w_valid", 32'(bus_w.pc_valid),   32'h0);
        check("rst_mid.a_pc",    bus_a.pc,              32'h0);
        check("rst_mid.a_halt",  32'(bus_a.halted),     32'h0);
        #1;
        rst = 1'b0;
        cyc("w_reboot", 2, 32'h0000, 1, 0, 0);
        check("a_reboot.pc",     bus_a.pc,              32'h0);
        check("a_reboot.valid",  32'(bus_a.pc_valid),   32'h1);
        cyc("w_reinc", 2, 32'h0004, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
